// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Constants and types shared by the register-file write arbiter and its
//   sub-blocks.
//     REG_AW / REG_DW / NREGS : default address width, data width and
//                               register count of the register file
//     REG_G0                  : address of %g0, which always reads as zero
//                               and therefore is never written
//     wr_state_e              : write-port FSM states
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREGS  = 32;
  localparam int REG_G0 = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } wr_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin priority picker. The request vector is rotated
//   so that position ptr_i lands on bit 0, the lowest set bit is chosen, and
//   the one-hot result is rotated back to the original requester positions.
//   Ports:
//     req_i  [NREQ]  request vector
//     ptr_i  [PW]    requester that currently has highest priority (< NREQ)
//     gnt_o  [NREQ]  one-hot winner, all zeros when no request is set
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [NREQ-1:0] rot_req;
  logic [NREQ-1:0] rot_gnt;
  logic [PW-1:0]   fwd_idx;
  logic [PW-1:0]   back_idx;
  logic            found;

  // Rotate requests so the highest-priority requester sits at bit 0.
  always_comb begin
    rot_req = '0;
    fwd_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      fwd_idx    = PW'((j + int'(ptr_i)) % NREQ);
      rot_req[j] = req_i[fwd_idx];
    end
  end

  // Fixed priority on the rotated vector: lowest set bit wins.
  always_comb begin
    rot_gnt = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (rot_req[j] && !found) begin
        rot_gnt[j] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Undo the rotation so the grant bit lines up with its requester.
  always_comb begin
    gnt_o    = '0;
    back_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      back_idx        = PW'((j + int'(ptr_i)) % NREQ);
      gnt_o[back_idx] = rot_gnt[j];
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port among NREQ requesters using a
//   round-robin arbiter with a registered grant. One write retires per clock:
//   the edge after a winner is chosen drives its grant pulse, its data on the
//   shared write bus, and a one-hot active-low load enable for the target
//   register cell.
//
//   Optional feature macro: REGFILE_WR_LOCK_EN
//     When defined, a lock input lets the current grantee keep the port for
//     consecutive writes (multi-register trap saves) via the LOCKED state.
//     When undefined there is no lock port and arbitration is pure
//     round-robin.
//
//   Ports:
//     Clk      in   1         clock, rising edge
//     Clr      in   1         asynchronous active-low reset
//     req      in   NREQ      level write request per requester
//     addr     in   NREQ*AW   target register per requester, slice i*AW +: AW
//     wdata    in   NREQ*DW   write data per requester, slice i*DW +: DW
//     lock     in   NREQ      (REGFILE_WR_LOCK_EN only) keep port for grantee
//     gnt      out  NREQ      registered one-hot grant pulse
//     loadE    out  NREGS     registered one-hot active-low load enables
//     wr_data  out  DW        registered write data to all register cells
//     busy     out  1         a load enable is active or the port is locked
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::REG_AW,
  parameter int DW    = regfile_pkg::REG_DW
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef REGFILE_WR_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREGS-1:0]   loadE,
  output logic [DW-1:0]      wr_data,
  output logic               busy
);

  import regfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_state_e        state_q,   state_d;
  logic [PW-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [NREQ-1:0]  gnt_q,     gnt_d;
  logic [NREGS-1:0] loadE_q,   loadE_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             busy_q,    busy_d;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  arb_win;
  logic [NREQ-1:0]  sel;
  logic             hold;
  logic             win_any;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;

  // A requester sees its grant one cycle after the edge that issued it, so
  // its req is still high during that cycle. Masking the current grantee
  // keeps that stale request from being accepted as a second write.
  assign arb_req = (state_q == ST_IDLE) ? req : (req & ~gnt_q);

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_win)
  );

`ifdef REGFILE_WR_LOCK_EN
  // The grantee keeps the port while it holds both lock and req; the
  // round-robin choice is ignored for that cycle.
  assign hold = (state_q != ST_IDLE) && (|(gnt_q & lock & req));
`else
  assign hold = 1'b0;
`endif

  assign sel     = hold ? gnt_q : arb_win;
  assign win_any = |sel;

  // Steer the winner's index, address and data onto the shared path.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        win_idx  = PW'(i);
        win_addr = addr[i*AW +: AW];
        win_data = wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d   = ST_IDLE;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = sel;
    loadE_d   = '1;
    wr_data_d = wr_data_q;

    if (win_any) begin
      wr_data_d = win_data;

      // %g0 and addresses beyond the file are granted but not written.
      if ((int'(win_addr) != REG_G0) && (int'(win_addr) < NREGS)) begin
        loadE_d[win_addr] = 1'b0;
      end

      if (hold) begin
        // Pointer already sits past the locked requester; leave it there.
        state_d = ST_LOCKED;
      end else begin
        state_d  = ST_WRITE;
        rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end

    busy_d = (~&loadE_d) | (state_d == ST_LOCKED);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      loadE_q   <= '1;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      loadE_q   <= loadE_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign loadE   = loadE_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
//   Directed testbench for regfile_wr_arbiter with hand-computed expectations.
//   Build with +define+REGFILE_WR_LOCK_EN to include the lock scenario.
module tb_regfile_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic               Clk;
  logic               Clr;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
`ifdef REGFILE_WR_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREGS-1:0]   loadE;
  logic [DW-1:0]      wr_data;
  logic               busy;

  int n_chk;
  int n_fail;

  regfile_wr_arbiter #(
    .NREQ  (NREQ),
    .NREGS (NREGS),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
`ifdef REGFILE_WR_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .loadE   (loadE),
    .wr_data (wr_data),
    .busy    (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = AW'(i + 1);
      wdata[i*DW +: DW] = 32'h100 + 32'(i);
    end
    repeat (2) step();
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want %b", gnt, 4'b0000); end
    n_chk++; if (loadE !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_loadE: got %h want %h", loadE, 32'hFFFF_FFFF); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want %b", busy, 1'b0); end
    n_chk++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h want %h", wr_data, 32'h0); end
    #2 Clr = 1'b1;
    step();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_first_gnt: got %b want %b", gnt, 4'b0001); end
    n_chk++; if (loadE !== ~(32'h1 << 1)) begin n_fail++; $display("FAIL rst_first_loadE: got %h want %h", loadE, ~(32'h1 << 1)); end
    n_chk++; if (wr_data !== 32'h100) begin n_fail++; $display("FAIL rst_first_data: got %h want %h", wr_data, 32'h100); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_busy: got %b want %b", busy, 1'b1); end
    req = 4'b0000;
    step();
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_gnt: got %b want %b", gnt, 4'b0000); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want %b", busy, 1'b0); end
  endtask

  task automatic test_single_write();
    req = 4'b0100;
    addr[2*AW +: AW]  = 5'd5;
    wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    step();
    n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want %b", gnt, 4'b0100); end
    n_chk++; if (loadE !== ~(32'h1 << 5)) begin n_fail++; $display("FAIL single_loadE: got %h want %h", loadE, ~(32'h1 << 5)); end
    n_chk++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h want %h", wr_data, 32'hDEAD_BEEF); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want %b", busy, 1'b1); end
    req = 4'b0000;
    step();
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_after_gnt: got %b want %b", gnt, 4'b0000); end
    n_chk++; if (loadE !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL single_after_loadE: got %h want %h", loadE, 32'hFFFF_FFFF); end
    n_chk++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold_data: got %h want %h", wr_data, 32'hDEAD_BEEF); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_after_busy: got %b want %b", busy, 1'b0); end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] exp_gnt;
    // Restart from rr_ptr = 0 so the rotation begins at requester 0.
    Clr = 1'b0;
    #2 Clr = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = AW'(10 + i);
      wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      exp_gnt = 4'b0001 << (k % 4);
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rot_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); end
      n_chk++; if (loadE !== ~(32'h1 << (10 + k % 4))) begin n_fail++; $display("FAIL rot_loadE[%0d]: got %h want %h", k, loadE, ~(32'h1 << (10 + k % 4))); end
      n_chk++; if (wr_data !== 32'hA000_0000 + 32'(k % 4)) begin n_fail++; $display("FAIL rot_data[%0d]: got %h want %h", k, wr_data, 32'hA000_0000 + 32'(k % 4)); end
    end
    req = 4'b0000;
    step();
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rot_end_gnt: got %b want %b", gnt, 4'b0000); end
  endtask

  task automatic test_g0();
    req = 4'b0010;
    addr[1*AW +: AW]  = 5'd0;
    wdata[1*DW +: DW] = 32'h1234_5678;
    step();
    n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL g0_gnt: got %b want %b", gnt, 4'b0010); end
    n_chk++; if (loadE !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL g0_loadE: got %h want %h", loadE, 32'hFFFF_FFFF); end
    n_chk++; if (wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL g0_data: got %h want %h", wr_data, 32'h1234_5678); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL g0_busy: got %b want %b", busy, 1'b0); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_clr_mid();
    // rr_ptr is 2 here, so requester 3 wins first, then requester 0.
    req = 4'b1001;
    addr[3*AW +: AW]  = 5'd7;
    wdata[3*DW +: DW] = 32'h0000_55AA;
    addr[0*AW +: AW]  = 5'd9;
    wdata[0*DW +: DW] = 32'h0000_0909;
    step();
    n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL clr_pre_gnt3: got %b want %b", gnt, 4'b1000); end
    step();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL clr_pre_gnt0: got %b want %b", gnt, 4'b0001); end
    n_chk++; if (loadE !== ~(32'h1 << 9)) begin n_fail++; $display("FAIL clr_pre_loadE: got %h want %h", loadE, ~(32'h1 << 9)); end
    req = 4'b1000;
    Clr = 1'b0;
    #1;
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL clr_async_gnt: got %b want %b", gnt, 4'b0000); end
    n_chk++; if (loadE !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL clr_async_loadE: got %h want %h", loadE, 32'hFFFF_FFFF); end
    n_chk++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL clr_async_data: got %h want %h", wr_data, 32'h0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_async_busy: got %b want %b", busy, 1'b0); end
    step();
    Clr = 1'b1;
    step();
    n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL clr_rel_gnt: got %b want %b", gnt, 4'b1000); end
    n_chk++; if (loadE !== ~(32'h1 << 7)) begin n_fail++; $display("FAIL clr_rel_loadE: got %h want %h", loadE, ~(32'h1 << 7)); end
    n_chk++; if (wr_data !== 32'h0000_55AA) begin n_fail++; $display("FAIL clr_rel_data: got %h want %h", wr_data, 32'h0000_55AA); end
    req = 4'b0000;
    step();
  endtask

`ifdef REGFILE_WR_LOCK_EN
  task automatic test_lock();
    // rr_ptr is 0 here; requester 0 wins and then keeps the port via lock.
    req  = 4'b0011;
    lock = 4'b0001;
    addr[1*AW +: AW]  = 5'd3;
    wdata[1*DW +: DW] = 32'hBBBB_0001;
    for (int k = 0; k < 3; k++) begin
      addr[0*AW +: AW]  = AW'(16 + k);
      wdata[0*DW +: DW] = 32'hCAFE_0000 + 32'(k);
      step();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, 4'b0001); end
      n_chk++; if (loadE !== ~(32'h1 << (16 + k))) begin n_fail++; $display("FAIL lock_loadE[%0d]: got %h want %h", k, loadE, ~(32'h1 << (16 + k))); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_busy[%0d]: got %b want %b", k, busy, 1'b1); end
    end
    lock = 4'b0000;
    req  = 4'b0010;
    step();
    n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_release_gnt: got %b want %b", gnt, 4'b0010); end
    n_chk++; if (loadE !== ~(32'h1 << 3)) begin n_fail++; $display("FAIL lock_release_loadE: got %h want %h", loadE, ~(32'h1 << 3)); end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Clr    = 1'b0;
    req    = '0;
    addr   = '0;
    wdata  = '0;
`ifdef REGFILE_WR_LOCK_EN
    lock   = '0;
`endif
    test_reset();
    test_single_write();
    test_rotation();
    test_g0();
    test_clr_mid();
`ifdef REGFILE_WR_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
